// File: rtl/misaligned_store_split.sv
// misaligned_store_split: turns one byte/half/word store at any byte address
// into one or two word-aligned memory beats with byte enables, stalling the
// upstream store stage until every beat has been accepted.
// Optional feature macro: MISALIGN_TRAP_EN rejects word-crossing stores with a
// one-cycle misalign_fault pulse instead of splitting them.
module misaligned_store_split #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              st_stall,
  output logic              st_done,
  output logic              misalign_fault,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be
);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        size_q, size_d;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] s);
    case (s)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] data_mask(input logic [1:0] s);
    case (s)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // A store crosses when its last byte lands in the next word (3-bit sum).
  function automatic logic crosses(input logic [1:0] o, input logic [1:0] s);
    logic [2:0] sum;
    sum = {1'b0, o} + size_bytes(s);
    return sum > 3'd4;
  endfunction

  // Beat fields derived from the latched request (data already masked).
  logic [1:0]        off;
  logic [2:0]        rem;
  logic [3:0]        m;
  logic              cross_q;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [3:0]        be0, be1;
  logic [31:0]       wd0, wd1;

  assign off     = addr_q[1:0];
  assign rem     = 3'd4 - {1'b0, off};
  assign m       = size_mask(size_q);
  assign cross_q = crosses(off, size_q);
  assign addr0   = {addr_q[ADDR_W-1:2], 2'b00};
  assign addr1   = addr0 + ADDR_W'(4);
  assign be0     = m << off;
  assign be1     = m >> rem;
  assign wd0     = data_q << {off, 3'b000};
  assign wd1     = data_q >> {rem, 3'b000};

  logic trap_hit;

`ifdef MISALIGN_TRAP_EN
  logic fault_q;

  assign trap_hit = (state_q == IDLE) && st_valid && crosses(st_addr[1:0], st_size);

  // Fault pulse follows the rejected request by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= trap_hit;
  end

  assign misalign_fault = fault_q;
`else
  assign trap_hit       = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  // State and request registers; reset drops any pending beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
    end
  end

  // Next-state, request latch and beat outputs; memory outputs are zero in IDLE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    size_d    = size_q;
    st_done   = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state_q)
      IDLE: begin
        if (st_valid && !trap_hit) begin
          addr_d  = st_addr;
          data_d  = st_data & data_mask(st_size);
          size_d  = st_size;
          state_d = BEAT0;
        end
      end
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = addr0;
        mem_wdata = wd0;
        mem_be    = be0;
        if (mem_ready) begin
          if (cross_q) begin
            state_d = BEAT1;
          end else begin
            state_d = IDLE;
            st_done = 1'b1;
          end
        end
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = addr1;
        mem_wdata = wd1;
        mem_be    = be1;
        if (mem_ready) begin
          state_d = IDLE;
          st_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign st_stall = (state_q != IDLE);

endmodule

// File: tb/tb_misaligned_store_split.sv
// Testbench for misaligned_store_split: directed and randomized stores checked
// against a byte-by-byte model of which word and lane each store byte lands in.
module tb_misaligned_store_split;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_stall;
  logic        st_done;
  logic        misalign_fault;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  misaligned_store_split #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size), .st_stall(st_stall), .st_done(st_done),
    .misalign_fault(misalign_fault), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model results
  int          exp_nb;
  logic [31:0] exp_addr [2];
  logic [3:0]  exp_be   [2];
  logic [31:0] exp_wd   [2];

  // Observed transaction
  int          obs_nb, obs_done, obs_cyc, obs_stalls, obs_unstable, obs_bad, obs_fault, obs_timeout;
  logic [31:0] obs_addr [4];
  logic [3:0]  obs_be   [4];
  logic [31:0] obs_wd   [4];

  // Place every store byte at its own byte address, group by containing word.
  task automatic model(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] dat);
    int n;
    logic [31:0] first, ba, wa;
    int lane, idx;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    first = a & 32'hFFFF_FFFC;
    exp_nb = 1;
    for (int i = 0; i < 2; i++) begin
      exp_addr[i] = '0; exp_be[i] = '0; exp_wd[i] = '0;
    end
    for (int k = 0; k < n; k++) begin
      ba   = a + k;
      wa   = ba & 32'hFFFF_FFFC;
      lane = int'(ba[1:0]);
      idx  = (wa == first) ? 0 : 1;
      if (idx == 1) exp_nb = 2;
      exp_addr[idx]             = wa;
      exp_be[idx][lane]         = 1'b1;
      exp_wd[idx][8*lane +: 8]  = dat[8*k +: 8];
    end
  endtask

  // Issue one store from IDLE (called at a negedge), record what memory sees.
  task automatic run_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] dat,
                           input int mode);
    logic [31:0] pa, pw;
    logic [3:0]  pb;
    logic        held;
    int          cyc;
    obs_nb = 0; obs_done = 0; obs_cyc = 0; obs_stalls = 0; obs_unstable = 0;
    obs_bad = 0; obs_fault = 0; obs_timeout = 0;
    held = 1'b0; pa = '0; pw = '0; pb = '0;
    st_valid = 1'b1; st_addr = a; st_size = sz; st_data = dat;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    if (st_stall || mem_valid || st_done) obs_bad++;
    @(negedge clk);
    st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_size = 2'($urandom_range(0, 3));
    cyc = 0;
    while (1) begin
      cyc++;
      case (mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = (cyc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
        default: mem_ready = (cyc > 3);
      endcase
      #1;
      if (misalign_fault) obs_fault++;
      if (!mem_valid || !st_stall) obs_bad++;
      if (held && (mem_addr !== pa || mem_be !== pb || mem_wdata !== pw)) obs_unstable++;
      if (mem_valid && !mem_ready) obs_stalls++;
      if (st_done && !(mem_valid && mem_ready)) obs_bad++;
      if (mem_valid && mem_ready && obs_nb < 4) begin
        obs_addr[obs_nb] = mem_addr; obs_be[obs_nb] = mem_be; obs_wd[obs_nb] = mem_wdata;
        obs_nb++;
      end
      held = mem_valid && !mem_ready;
      pa = mem_addr; pb = mem_be; pw = mem_wdata;
      if (st_done) begin obs_done++; obs_cyc = cyc; break; end
      if (cyc >= 40) begin obs_timeout = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    if (mem_valid || st_stall || st_done || misalign_fault) obs_bad++;
  endtask

  task automatic test_reset();
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({mem_valid, st_stall, st_done, misalign_fault} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_valid, st_stall, st_done, misalign_fault});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, mem_be} !== 68'd0) begin
      n_fail++; $display("FAIL reset_data: addr %h wdata %h be %b expected all zero", mem_addr, mem_wdata, mem_be);
    end
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_valid, st_stall, st_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_hold: got %b expected 000", {mem_valid, st_stall, st_done});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ta [5];
    logic [1:0]  ts [5];
    logic [31:0] td [5];
    ta[0] = 32'h0000_0100; ts[0] = 2'b10; td[0] = 32'hAABB_CCDD;
    ta[1] = 32'h0000_0102; ts[1] = 2'b10; td[1] = 32'hAABB_CCDD;
    ta[2] = 32'h0000_0203; ts[2] = 2'b01; td[2] = 32'h5555_1234;
    ta[3] = 32'hFFFF_FFFF; ts[3] = 2'b11; td[3] = 32'h1122_3344;
    ta[4] = 32'h0000_0103; ts[4] = 2'b00; td[4] = 32'h9999_99EF;
    for (int t = 0; t < 5; t++) begin
      model(ta[t], ts[t], td[t]);
`ifdef MISALIGN_TRAP_EN
      if (exp_nb == 2) continue;
`endif
      run_store(ta[t], ts[t], td[t], 0);
      n_checks++;
      if (obs_nb !== exp_nb || obs_done !== 1 || obs_timeout !== 0) begin
        n_fail++; $display("FAIL dir%0d_beats: got %0d beats %0d done expected %0d beats 1 done", t, obs_nb, obs_done, exp_nb);
      end
      for (int i = 0; i < exp_nb && i < obs_nb; i++) begin
        n_checks++;
        if (obs_addr[i] !== exp_addr[i] || obs_be[i] !== exp_be[i] || obs_wd[i] !== exp_wd[i]) begin
          n_fail++; $display("FAIL dir%0d_beat%0d: got %h/%b/%h expected %h/%b/%h", t, i,
                             obs_addr[i], obs_be[i], obs_wd[i], exp_addr[i], exp_be[i], exp_wd[i]);
        end
      end
      n_checks++;
      if (obs_cyc !== exp_nb || obs_bad !== 0 || obs_fault !== 0) begin
        n_fail++; $display("FAIL dir%0d_latency: got %0d cycles %0d protocol errs expected %0d cycles 0 errs", t, obs_cyc, obs_bad, exp_nb);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    a = 32'h0000_0102;
`ifdef MISALIGN_TRAP_EN
    a = 32'h0000_0100;
`endif
    model(a, 2'b10, 32'hAABB_CCDD);
    run_store(a, 2'b10, 32'hAABB_CCDD, 2);
    n_checks++;
    if (obs_stalls !== 3 || obs_unstable !== 0) begin
      n_fail++; $display("FAIL stall_hold: got %0d stalls %0d changes expected 3 stalls 0 changes", obs_stalls, obs_unstable);
    end
    n_checks++;
    if (obs_cyc !== exp_nb + 3 || obs_done !== 1 || obs_bad !== 0 || obs_nb !== exp_nb) begin
      n_fail++; $display("FAIL stall_resume: got cyc %0d done %0d errs %0d beats %0d expected cyc %0d done 1 errs 0 beats %0d",
                         obs_cyc, obs_done, obs_bad, obs_nb, exp_nb + 3, exp_nb);
    end
    for (int i = 0; i < exp_nb && i < obs_nb; i++) begin
      n_checks++;
      if (obs_addr[i] !== exp_addr[i] || obs_be[i] !== exp_be[i] || obs_wd[i] !== exp_wd[i]) begin
        n_fail++; $display("FAIL stall_beat%0d: got %h/%b/%h expected %h/%b/%h", i,
                           obs_addr[i], obs_be[i], obs_wd[i], exp_addr[i], exp_be[i], exp_wd[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] a;
    a = 32'h0000_0102;
`ifdef MISALIGN_TRAP_EN
    a = 32'h0000_0100;
`endif
    st_valid = 1'b1; st_addr = a; st_size = 2'b10; st_data = 32'hAABB_CCDD; mem_ready = 1'b0;
    @(negedge clk);
    st_valid = 1'b0;
`ifndef MISALIGN_TRAP_EN
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
`endif
    #1;
    n_checks++;
    if (!mem_valid || mem_addr !== ((a & 32'hFFFF_FFFC) + ((a[1:0] != 2'b00) ? 32'd4 : 32'd0))) begin
      n_fail++; $display("FAIL rst_pre: got valid %b addr %h expected valid 1 in second beat", mem_valid, mem_addr);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({mem_valid, mem_be, st_stall, st_done} !== 7'd0) begin
      n_fail++; $display("FAIL rst_async: got valid %b be %b stall %b done %b expected all 0", mem_valid, mem_be, st_stall, st_done);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_valid, st_stall, st_done} !== 3'b000) begin
      n_fail++; $display("FAIL rst_release: got %b expected 000", {mem_valid, st_stall, st_done});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({mem_valid, st_stall, st_done} !== 3'b000) begin
      n_fail++; $display("FAIL rst_idle: got %b expected 000", {mem_valid, st_stall, st_done});
    end
    @(negedge clk);
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_trap();
    st_valid = 1'b1; st_addr = 32'h0000_0101; st_size = 2'b10; st_data = 32'hAABB_CCDD; mem_ready = 1'b1;
    #1;
    n_checks++;
    if (misalign_fault !== 1'b0 || mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL trap_early: got fault %b valid %b expected 0 0", misalign_fault, mem_valid);
    end
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    n_checks++;
    if (misalign_fault !== 1'b1 || mem_valid !== 1'b0 || st_stall !== 1'b0) begin
      n_fail++; $display("FAIL trap_pulse: got fault %b valid %b stall %b expected 1 0 0", misalign_fault, mem_valid, st_stall);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (misalign_fault !== 1'b0 || mem_valid !== 1'b0 || st_done !== 1'b0) begin
      n_fail++; $display("FAIL trap_end: got fault %b valid %b done %b expected 0 0 0", misalign_fault, mem_valid, st_done);
    end
    @(negedge clk);
    model(32'h0000_0103, 2'b00, 32'h0000_00EF);
    run_store(32'h0000_0103, 2'b00, 32'h0000_00EF, 0);
    n_checks++;
    if (obs_nb !== 1 || obs_addr[0] !== exp_addr[0] || obs_be[0] !== exp_be[0] || obs_wd[0] !== exp_wd[0] || obs_done !== 1) begin
      n_fail++; $display("FAIL trap_byte: got %0d beats %h/%b/%h expected 1 beat %h/%b/%h",
                         obs_nb, obs_addr[0], obs_be[0], obs_wd[0], exp_addr[0], exp_be[0], exp_wd[0]);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          mode, bad;
    for (int t = 0; t < 80; t++) begin
      a  = $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      d  = $urandom;
      mode = $urandom_range(0, 1);
      model(a, sz, d);
`ifdef MISALIGN_TRAP_EN
      if (exp_nb == 2) begin
        st_valid = 1'b1; st_addr = a; st_size = sz; st_data = d;
        @(negedge clk);
        st_valid = 1'b0;
        #1;
        n_checks++;
        if (misalign_fault !== 1'b1 || mem_valid !== 1'b0 || st_stall !== 1'b0) begin
          n_fail++; $display("FAIL rnd%0d_trap: got fault %b valid %b expected 1 0", t, misalign_fault, mem_valid);
        end
        @(negedge clk);
        continue;
      end
`endif
      run_store(a, sz, d, mode);
      bad = 0;
      if (obs_nb !== exp_nb || obs_done !== 1 || obs_timeout !== 0) bad = 1;
      for (int i = 0; i < exp_nb && i < obs_nb; i++)
        if (obs_addr[i] !== exp_addr[i] || obs_be[i] !== exp_be[i] || obs_wd[i] !== exp_wd[i]) bad = 1;
      if (obs_cyc !== exp_nb + obs_stalls || obs_unstable !== 0 || obs_bad !== 0 || obs_fault !== 0) bad = 1;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL rnd%0d: addr %h size %0d got %0d beats b0 %h/%b/%h cyc %0d errs %0d expected %0d beats b0 %h/%b/%h cyc %0d",
                 t, a, sz, obs_nb, obs_addr[0], obs_be[0], obs_wd[0], obs_cyc, obs_bad + obs_unstable + obs_fault,
                 exp_nb, exp_addr[0], exp_be[0], exp_wd[0], exp_nb + obs_stalls);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_async_reset();
`ifdef MISALIGN_TRAP_EN
    test_trap();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
